// File: rtl/toggle_debounce.sv
// Pushbutton debouncer driving a downstream T flip-flop: one T pulse per accepted
// press, optional auto-repeat while held, and a running count of issued pulses.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | button released and stable; waiting for a high sample
// DB_PRESS   | qualifying a press; cnt = consecutive high samples seen
// HELD       | press accepted; repeat timer runs while the button stays high
// DB_RELEASE | qualifying a release; cnt = consecutive low samples seen
module toggle_debounce #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter bit          RPT_EN     = 1'b1,
    parameter int unsigned RPT_DELAY  = 16,
    parameter int unsigned RPT_PERIOD = 8
) (
    input  logic       Clk,
    input  logic       SR,
    input  logic       Btn,
    output logic       T,
    output logic       Level,
    output logic [7:0] PulseCnt
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST    = 16'(DB_CYCLES - 1);
    localparam logic [15:0] RPT_FIRST  = 16'(RPT_DELAY - 1);
    localparam logic [15:0] RPT_RELOAD = 16'(RPT_DELAY - RPT_PERIOD);

    state_t      state;
    state_t      state_next;
    logic        btn_meta;
    logic        btn_s;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [15:0] rpt;
    logic [15:0] rpt_next;
    logic        t_next;

    always_ff @(posedge Clk) begin
        if (!SR) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            state    <= IDLE;
            cnt      <= 16'd0;
            rpt      <= 16'd0;
            T        <= 1'b0;
            Level    <= 1'b0;
            PulseCnt <= 8'd0;
        end else begin
            btn_meta <= Btn;
            btn_s    <= btn_meta;
            state    <= state_next;
            cnt      <= cnt_next;
            rpt      <= rpt_next;
            T        <= t_next;
            // Registered from next state so Level tracks the state register exactly.
            Level    <= (state_next == HELD) || (state_next == DB_RELEASE);
            if (T) begin
                PulseCnt <= PulseCnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rpt_next   = rpt;
        t_next     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 16'd0;
                rpt_next = 16'd0;
                if (btn_s) begin
                    state_next = DB_PRESS;
                    cnt_next   = 16'd1;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else if (cnt == DB_LAST) begin
                    state_next = HELD;
                    cnt_next   = 16'd0;
                    rpt_next   = 16'd0;
                    t_next     = 1'b1;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = DB_RELEASE;
                    cnt_next   = 16'd1;
                    rpt_next   = 16'd0;
                end else if (RPT_EN) begin
                    // After the first repeat, reloading keeps later pulses RPT_PERIOD apart.
                    if (rpt == RPT_FIRST) begin
                        t_next   = 1'b1;
                        rpt_next = RPT_RELOAD;
                    end else begin
                        rpt_next = rpt + 16'd1;
                    end
                end else begin
                    rpt_next = 16'd0;
                end
            end
            DB_RELEASE: begin
                if (btn_s) begin
                    state_next = HELD;
                    cnt_next   = 16'd0;
                    rpt_next   = 16'd0;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
                rpt_next   = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_toggle_debounce.sv
// Directed bench for toggle_debounce: one default instance and one with auto-repeat
// disabled, both fed the same button; T pulse edges are logged per instance.
module tb_toggle_debounce;

    logic       clk = 1'b0;
    logic       sr  = 1'b0;
    logic       btn = 1'b0;
    logic       t;
    logic       level;
    logic [7:0] pulse_cnt;
    logic       t_nr;
    logic       level_nr;
    logic [7:0] pulse_cnt_nr;

    int checks     = 0;
    int failures   = 0;
    int edge_idx   = 0;
    int consec_err = 0;
    int t_edges[$];
    int t_nr_edges[$];
    logic t_prev    = 1'b0;
    logic t_nr_prev = 1'b0;

    int p0;
    int b0;
    int r0;
    int rpt_off[7] = '{0, 16, 24, 32, 40, 48, 56};
    logic [6:0] pat = 7'b1111011;

    always #5 clk = ~clk;

    toggle_debounce dut (
        .Clk      (clk),
        .SR       (sr),
        .Btn      (btn),
        .T        (t),
        .Level    (level),
        .PulseCnt (pulse_cnt)
    );

    toggle_debounce #(.RPT_EN(1'b0)) dut_nr (
        .Clk      (clk),
        .SR       (sr),
        .Btn      (btn),
        .T        (t_nr),
        .Level    (level_nr),
        .PulseCnt (pulse_cnt_nr)
    );

    // Log the edge number after which T was seen high, and any back-to-back pulse.
    always @(posedge clk) begin
        edge_idx = edge_idx + 1;
        #2;
        if (t === 1'b1) t_edges.push_back(edge_idx);
        if (t_nr === 1'b1) t_nr_edges.push_back(edge_idx);
        if ((t === 1'b1 && t_prev === 1'b1) || (t_nr === 1'b1 && t_nr_prev === 1'b1))
            consec_err = consec_err + 1;
        t_prev    = t;
        t_nr_prev = t_nr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_log();
        t_edges.delete();
        t_nr_edges.delete();
    endtask

    task automatic do_reset();
        sr = 1'b0;
        step(2);
        sr = 1'b1;
    endtask

    function automatic int t_at(input int i);
        return (i < t_edges.size()) ? t_edges[i] : -1;
    endfunction

    function automatic int t_nr_at(input int i);
        return (i < t_nr_edges.size()) ? t_nr_edges[i] : -1;
    endfunction

    initial begin
        // Reset state
        step(3);
        chk("rst_t", t, 0);
        chk("rst_level", level, 0);
        chk("rst_pulse_cnt", pulse_cnt, 0);
        sr = 1'b1;

        // Clean press: Btn first sampled high at p0, T high only after p0+5
        clear_log();
        p0  = edge_idx + 1;
        btn = 1'b1;
        step(5);
        chk("press_t_early", t, 0);
        chk("press_level_early", level, 0);
        step(1);
        chk("press_t", t, 1);
        chk("press_level", level, 1);
        chk("press_cnt_before", pulse_cnt, 0);
        step(1);
        chk("press_t_off", t, 0);
        chk("press_cnt_after", pulse_cnt, 1);
        step(7);
        btn = 1'b0;
        step(12);
        chk("press_level_released", level, 0);
        chk("press_pulses", t_edges.size(), 1);
        chk("press_edge", t_at(0), p0 + 5);
        chk("press_cnt_final", pulse_cnt, 1);

        // Bounce 1,1,0,1,1,1,1: low reaches Btn_s at b0+3, pulse 5 edges later
        clear_log();
        b0 = edge_idx + 1;
        for (int i = 0; i < 7; i++) begin
            btn = pat[i];
            step(1);
        end
        btn = 1'b1;
        step(1);
        chk("bounce_level_early", level, 0);
        chk("bounce_t_early", t, 0);
        step(1);
        chk("bounce_t", t, 1);
        step(5);
        chk("bounce_pulses", t_edges.size(), 1);
        chk("bounce_edge", t_at(0), b0 + 8);
        chk("bounce_cnt", pulse_cnt, 2);
        btn = 1'b0;
        step(12);

        // Auto-repeat: held 60 cycles past press pulse
        do_reset();
        clear_log();
        p0  = edge_idx + 1;
        btn = 1'b1;
        step(66);
        btn = 1'b0;
        step(12);
        chk("rpt_pulses", t_edges.size(), 7);
        for (int i = 0; i < 7; i++) chk("rpt_edge", t_at(i), p0 + 5 + rpt_off[i]);
        chk("rpt_cnt", pulse_cnt, 7);
        chk("rpt_nr_pulses", t_nr_edges.size(), 1);
        chk("rpt_nr_cnt", pulse_cnt_nr, 1);

        // Repeat disabled: held 100 cycles, release needs DB_CYCLES low samples
        do_reset();
        clear_log();
        p0  = edge_idx + 1;
        btn = 1'b1;
        step(105);
        btn = 1'b0;
        r0  = p0 + 105;
        step(5);
        chk("nr_level_held", level_nr, 1);
        step(1);
        chk("nr_level_released", level_nr, 0);
        chk("nr_pulses", t_nr_edges.size(), 1);
        chk("nr_edge", t_nr_at(0), p0 + 5);
        chk("nr_cnt", pulse_cnt_nr, 1);
        step(5);

        // PulseCnt wrap after 256 presses
        do_reset();
        clear_log();
        for (int n = 0; n < 255; n++) begin
            btn = 1'b1;
            step(8);
            btn = 1'b0;
            step(8);
        end
        chk("wrap_cnt_255", pulse_cnt, 255);
        btn = 1'b1;
        step(8);
        btn = 1'b0;
        step(8);
        chk("wrap_cnt_0", pulse_cnt, 0);
        chk("wrap_nr_cnt_0", pulse_cnt_nr, 0);
        chk("wrap_pulses", t_edges.size(), 256);

        // Reset on the same edge a repeat pulse is due (p0+21)
        p0  = edge_idx + 1;
        btn = 1'b1;
        step(21);
        chk("due_cnt_before", pulse_cnt, 1);
        chk("due_t_before", t, 0);
        sr = 1'b0;
        step(1);
        chk("due_rst_t", t, 0);
        chk("due_rst_level", level, 0);
        chk("due_rst_cnt", pulse_cnt, 0);
        chk("due_rst_pulses", t_edges.size(), 257);

        // Button held through reset release counts as a new press
        sr = 1'b1;
        p0 = edge_idx + 1;
        step(5);
        chk("hold_rst_t_early", t, 0);
        step(1);
        chk("hold_rst_t", t, 1);
        chk("hold_rst_level", level, 1);
        btn = 1'b0;
        step(12);
        chk("no_consecutive_t", consec_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
